// File: rtl/spi_time_tx.sv
// SPI mode-0 master that sends a sync byte followed by a packed time-of-day payload, MSB first.
// Optional build macro SPI_TIME_TX_CHECKSUM_EN appends an XOR checksum byte (48-bit frame instead of 40).
module spi_time_tx #(
    parameter int          CLKDIV    = 20,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [4:0] hour_in,
    input  logic [5:0] minute_in,
    input  logic [5:0] second_in,
    input  logic [3:0] month_in,
    input  logic [4:0] day_in,
    input  logic [5:0] year_in,
    output logic       ready,
    output logic       done,
    output logic       sclk,
    output logic       sdo,
    output logic       cs_n
);

    // state | meaning
    // IDLE  | cs_n high, waiting for start && ready
    // SHIFT | cs_n low, SCLK toggling every CLKDIV cycles, one bit per falling edge
    // HOLD  | cs_n low for CLKDIV cycles after the last falling edge
    // GAP   | cs_n high for CLKDIV cycles before the next frame may start
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

`ifdef SPI_TIME_TX_CHECKSUM_EN
    localparam int N = 48;
`else
    localparam int N = 40;
`endif

    localparam logic [7:0] CNT_RELOAD = 8'(CLKDIV - 1);
    localparam logic [5:0] BIT_LAST   = 6'(N - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_cnt;
    logic [5:0]     r_bit;
    logic [N-1:0]   r_shift;
    logic           r_sclk;
    logic           r_ready_en;

    logic           w_tc;
    logic           w_accept;
    logic [31:0]    w_payload;
    logic [N-1:0]   w_frame;

    assign w_tc      = (r_cnt == 8'd0);
    assign w_accept  = start && ready;
    assign w_payload = {hour_in, minute_in, second_in, month_in, day_in, year_in};

`ifdef SPI_TIME_TX_CHECKSUM_EN
    assign w_frame = {SYNC_BYTE, w_payload,
                      w_payload[31:24] ^ w_payload[23:16] ^ w_payload[15:8] ^ w_payload[7:0]};
`else
    assign w_frame = {SYNC_BYTE, w_payload};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                                  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_tc && r_sclk && (r_bit == 6'd0))         w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tc)                                      w_state_nxt = S_GAP;
            S_GAP:   if (w_tc)                                      w_state_nxt = S_IDLE;
            default:                                                w_state_nxt = S_IDLE;
        endcase
    end

    // Done marks the first GAP cycle, which is exactly when cs_n rises.
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        sclk  = 1'b0;
        sdo   = 1'b0;
        cs_n  = 1'b1;
        case (r_state)
            S_IDLE: ready = r_ready_en;
            S_SHIFT: begin
                cs_n = 1'b0;
                sclk = r_sclk;
                sdo  = r_shift[N-1];
            end
            S_HOLD: begin
                cs_n = 1'b0;
                sdo  = r_shift[N-1];
            end
            S_GAP: done = (r_cnt == CNT_RELOAD);
            default: ready = 1'b0;
        endcase
    end

    // Half-period timer, bit counter and shift register; SCLK toggles when the timer expires.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt      <= 8'd0;
            r_bit      <= 6'd0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= 1'b0;
                    if (w_accept) begin
                        r_shift <= w_frame;
                        r_cnt   <= CNT_RELOAD;
                        r_bit   <= BIT_LAST;
                    end
                end
                S_SHIFT: begin
                    if (w_tc) begin
                        r_cnt  <= CNT_RELOAD;
                        r_sclk <= ~r_sclk;
                        if (r_sclk) begin
                            r_shift <= {r_shift[N-2:0], 1'b0};
                            r_bit   <= r_bit - 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD, S_GAP: begin
                    r_sclk <= 1'b0;
                    if (w_tc) begin
                        r_cnt <= CNT_RELOAD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_sclk <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_time_tx.sv
// Self-checking bench for spi_time_tx: per-cycle reference model of the frame waveform,
// a table of directed frames, and hand-written busy / back-to-back / reset / stability sequences.
module tb_spi_time_tx;

    localparam int         D    = 2;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef SPI_TIME_TX_CHECKSUM_EN
    localparam int N = 48;
`else
    localparam int N = 40;
`endif
    localparam int T_CSLOW = D * (2 * N + 1);
    localparam int T_SHIFT = D * 2 * N;
    localparam int T_END   = D * (2 * N + 2) + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [4:0] hour_in;
    logic [5:0] minute_in;
    logic [5:0] second_in;
    logic [3:0] month_in;
    logic [4:0] day_in;
    logic [5:0] year_in;
    logic       ready, done, sclk, sdo, cs_n;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_sclk_r = 0;
    logic cap[$];

    spi_time_tx #(.CLKDIV(D), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hour_in(hour_in), .minute_in(minute_in), .second_in(second_in),
        .month_in(month_in), .day_in(day_in), .year_in(year_in),
        .ready(ready), .done(done), .sclk(sclk), .sdo(sdo), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) begin
        cap.push_back(sdo);
        n_sclk_r++;
    end

    always @(negedge clk) if (done === 1'b1) n_done++;

    function automatic logic [47:0] build_frame(input logic [4:0] h, input logic [5:0] mi,
                                                input logic [5:0] s, input logic [3:0] mo,
                                                input logic [4:0] d, input logic [5:0] y);
        logic [31:0] p;
        p = {h, mi, s, mo, d, y};
`ifdef SPI_TIME_TX_CHECKSUM_EN
        return {SYNC, p, p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]};
`else
        return {8'h00, SYNC, p};
`endif
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: waveform derived from cycle offset t since the accept cycle.
    int          m_t      = 0;
    bit          m_active = 1'b0;
    logic        m_rst_q  = 1'b0;
    logic [47:0] m_frame  = '0;

    always @(negedge clk) begin
        logic [4:0] act, exp, msk;
        act = {ready, cs_n, sclk, sdo, done};
        msk = 5'b11111;
        if (!m_rst_q) begin
            m_active = 1'b0;
            exp = 5'b01000;
        end else begin
            if (m_active) begin
                m_t++;
                if (m_t == T_END) m_active = 1'b0;
            end
            if (!m_active) begin
                exp = 5'b11000;
            end else begin
                exp[4] = 1'b0;
                exp[3] = (m_t > T_CSLOW);
                exp[2] = (m_t <= T_SHIFT) && ((((m_t - 1) / D) % 2) == 1);
                exp[1] = 1'b0;
                if (m_t <= T_SHIFT) exp[1] = m_frame[N - 1 - (m_t - 1) / (2 * D)];
                else if (m_t <= T_CSLOW) msk[1] = 1'b0;
                exp[0] = (m_t == T_CSLOW + 1);
            end
        end
        n_checks++;
        if (((act ^ exp) & msk) != 5'b0 || $isunknown(act)) begin
            n_fail++;
            $display("FAIL model_cycle t=%0d actual{rdy,csn,sclk,sdo,done}=%b required=%b mask=%b",
                     m_t, act, exp, msk);
        end
        if (m_rst_q && !m_active && reset_n && start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_frame  = build_frame(hour_in, minute_in, second_in, month_in, day_in, year_in);
        end
        m_rst_q = reset_n;
    end

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  mi;
        logic [5:0]  s;
        logic [3:0]  mo;
        logic [4:0]  d;
        logic [5:0]  y;
        logic [31:0] pay;
        logic [7:0]  ck;
    } vec_t;

    task automatic set_fields(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                              input logic [3:0] mo, input logic [4:0] d, input logic [5:0] y);
        hour_in = h; minute_in = mi; second_in = s; month_in = mo; day_in = d; year_in = y;
    endtask

    task automatic rand_fields();
        set_fields(5'($urandom), 6'($urandom), 6'($urandom), 4'($urandom), 5'($urandom), 6'($urandom));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) break;
        end
        if (k == 1000) chk("wait_idle_timeout", 48'd0, 48'd1);
    endtask

    function automatic logic [47:0] cap_value();
        logic [47:0] v;
        v = '0;
        foreach (cap[i]) v = {v[46:0], cap[i]};
        return v;
    endfunction

    // Accept a frame and run it to done; reports cs_n low count, done cycle and captured bits.
    // When toggle is set, the inputs are scrambled every cycle after accept.
    task automatic run_frame(input bit toggle, output int low, output int dcyc, output logic [47:0] got);
        int cyc;
        wait_idle();
        cap.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        low = 0;
        dcyc = -1;
        for (cyc = 1; cyc < 1000; cyc++) begin
            if (toggle) rand_fields();
            if (cs_n === 1'b0) low++;
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        got = cap_value();
        chk("frame_bit_count", 48'(cap.size()), 48'(N));
    endtask

    vec_t        tbl[6];
    int          low, dcyc, hi, d0, k;
    logic [47:0] got, exp_f, fb;
    logic [4:0]  ah; logic [5:0] ami, as_, ay; logic [3:0] amo; logic [4:0] ad;

    initial begin
        tbl[0] = '{5'd10, 6'd30, 6'd45, 4'd11, 5'd17, 6'd14, 32'h53D6DC4E, 8'h17};
        tbl[1] = '{5'd0,  6'd0,  6'd0,  4'd0,  5'd0,  6'd0,  32'h00000000, 8'h00};
        tbl[2] = '{5'd31, 6'd63, 6'd63, 4'd15, 5'd31, 6'd63, 32'hFFFFFFFF, 8'h00};
        tbl[3] = '{5'd31, 6'd0,  6'd0,  4'd0,  5'd0,  6'd0,  32'hF8000000, 8'hF8};
        tbl[4] = '{5'd0,  6'd0,  6'd0,  4'd15, 5'd0,  6'd0,  32'h00007800, 8'h78};
        tbl[5] = '{5'd0,  6'd0,  6'd0,  4'd0,  5'd0,  6'd1,  32'h00000001, 8'h01};

        reset_n = 1'b0;
        start   = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 48'(cs_n), 48'd1);
        chk("rst_ready", 48'(ready), 48'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 48'(ready), 48'd1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
`ifdef SPI_TIME_TX_CHECKSUM_EN
            exp_f = {SYNC, tbl[i].pay, tbl[i].ck};
`else
            exp_f = {8'h00, SYNC, tbl[i].pay};
`endif
            set_fields(tbl[i].h, tbl[i].mi, tbl[i].s, tbl[i].mo, tbl[i].d, tbl[i].y);
            run_frame(1'b0, low, dcyc, got);
            chk($sformatf("tbl%0d_bits", i), got, exp_f);
            chk($sformatf("tbl%0d_cs_low", i), 48'(low), 48'(T_CSLOW));
            chk($sformatf("tbl%0d_done_cyc", i), 48'(dcyc), 48'(T_CSLOW + 1));
        end

        // Start pulsed while busy: ignored, exactly one done
        wait_idle();
        rand_fields();
        d0 = n_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("busy_ready_low", 48'(ready), 48'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (T_END + 20) @(posedge clk);
        #1;
        chk("busy_one_done", 48'(n_done - d0), 48'd1);

        // Back-to-back with start held; inputs change mid-frame
        wait_idle();
        rand_fields();
        start = 1'b1;
        @(posedge clk); #1;
        repeat (30) @(posedge clk);
        #1;
        rand_fields();
        {ah, ami, as_, amo, ad, ay} = {hour_in, minute_in, second_in, month_in, day_in, year_in};
        for (k = 0; k < 1000 && done !== 1'b1; k++) begin @(posedge clk); #1; end
        chk("b2b_first_done_seen", 48'(done), 48'd1);
        cap.delete();
        hi = 0;
        for (k = 0; k < 1000 && cs_n === 1'b1; k++) begin hi++; @(posedge clk); #1; end
        chk("b2b_gap_ge_clkdiv", 48'(hi >= D), 48'd1);
        for (k = 0; k < 1000 && done !== 1'b1; k++) begin @(posedge clk); #1; end
        start = 1'b0;
        fb = build_frame(ah, ami, as_, amo, ad, ay);
        chk("b2b_second_bits", cap_value(), fb);

        // Reset mid-frame at cycle 60
        wait_idle();
        rand_fields();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        d0 = n_done;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_csn_sclk_sdo_done_rdy", 48'({cs_n, sclk, sdo, done, ready}), 48'b10000);
        reset_n = 1'b1;
        hi = n_sclk_r;
        @(posedge clk); #1;
        chk("midrst_ready_after_release", 48'(ready), 48'd1);
        repeat (T_END) @(posedge clk);
        #1;
        chk("midrst_no_done", 48'(n_done - d0), 48'd0);
        chk("midrst_no_sclk", 48'(n_sclk_r - hi), 48'd0);

        // Inputs toggled every cycle after accept
        for (int i = 0; i < 2; i++) begin
            wait_idle();
            rand_fields();
            fb = build_frame(hour_in, minute_in, second_in, month_in, day_in, year_in);
            run_frame(1'b1, low, dcyc, got);
            chk($sformatf("stable%0d_bits", i), got, fb);
        end

        // Random frames with random idle spacing
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            rand_fields();
            fb = build_frame(hour_in, minute_in, second_in, month_in, day_in, year_in);
            run_frame(1'b0, low, dcyc, got);
            chk($sformatf("rand%0d_bits", i), got, fb);
            chk($sformatf("rand%0d_done_cyc", i), 48'(dcyc), 48'(T_CSLOW + 1));
        end

        repeat (T_END + 5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
